// File: rtl/cmp_bist_pkg.sv
// Shared definitions for the comparator self-test sequencer: state encoding,
// response bit positions and the default operand width.
package cmp_bist_pkg;

  localparam int DEF_WIDTH = 2;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_WAIT  = 2'd1,
    ST_CHECK = 2'd2,
    ST_DONE  = 2'd3
  } bist_state_e;

  // Response triples are packed as {gt, eq, lt}.
  localparam int RESP_GT = 2;
  localparam int RESP_EQ = 1;
  localparam int RESP_LT = 0;

endpackage

// File: rtl/cmp_ref_model.sv
// Golden unsigned comparator: the response a correct comparator must give
// for operands a and b, packed {gt, eq, lt}.
module cmp_ref_model
  import cmp_bist_pkg::*;
#(
  parameter int WIDTH = DEF_WIDTH
) (
  input  logic [WIDTH-1:0] a_i,
  input  logic [WIDTH-1:0] b_i,
  output logic [2:0]       resp_o
);

  // Expected response bits for the current operand pair.
  always_comb begin
    resp_o          = 3'b000;
    resp_o[RESP_GT] = (a_i > b_i);
    resp_o[RESP_EQ] = (a_i == b_i);
    resp_o[RESP_LT] = (a_i < b_i);
  end

endmodule

// File: rtl/cmp_bist_ctrl.sv
// Self-test sequencer for the magnitude comparator: sweeps every operand pair,
// waits SETTLE cycles per pair, checks the response and records the outcome.
module cmp_bist_ctrl
  import cmp_bist_pkg::*;
#(
  parameter int WIDTH  = DEF_WIDTH,
  parameter int SETTLE = 1,
  parameter int ERRW   = 2 * WIDTH + 1
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  input  logic             abort,
  output logic             busy,
  output logic             done,
  output logic             pass,
  output logic [ERRW-1:0]  err_count,
  output logic [WIDTH-1:0] fail_a,
  output logic [WIDTH-1:0] fail_b,
  output logic [2:0]       fail_obs,
  output logic [WIDTH-1:0] cmp_a,
  output logic [WIDTH-1:0] cmp_b,
  input  logic             cmp_gt,
  input  logic             cmp_eq,
  input  logic             cmp_lt
);

  localparam int               SW          = (SETTLE > 1) ? $clog2(SETTLE) : 1;
  localparam logic [SW-1:0]    SETTLE_LAST = (SETTLE > 0) ? SW'(SETTLE - 1) : '0;
  localparam logic [SW-1:0]    SETTLE_ONE  = SW'(1);
  localparam logic [WIDTH-1:0] OP_MAX      = '1;
  localparam logic [WIDTH-1:0] OP_ONE      = WIDTH'(1);
  localparam logic [ERRW-1:0]  ERR_ONE     = ERRW'(1);
  // With no settle time each vector is checked straight away.
  localparam bist_state_e      ST_FIRST    = (SETTLE > 0) ? ST_WAIT : ST_CHECK;

  bist_state_e      state_q, state_d;
  logic [WIDTH-1:0] a_q, a_d, b_q, b_d;
  logic [SW-1:0]    settle_q, settle_d;
  logic             busy_q, busy_d, done_q, done_d, pass_q, pass_d;
  logic [ERRW-1:0]  err_q, err_d;
  logic [WIDTH-1:0] fa_q, fa_d, fb_q, fb_d;
  logic [2:0]       fo_q, fo_d;

  logic [2:0]       obs_s;
  logic [2:0]       exp_s;
  logic             mismatch_s;
  logic             last_vec_s;
  logic             settle_end_s;

  cmp_ref_model #(.WIDTH(WIDTH)) u_ref (
    .a_i    (a_q),
    .b_i    (b_q),
    .resp_o (exp_s)
  );

  always_comb begin
    obs_s          = 3'b000;
    obs_s[RESP_GT] = cmp_gt;
    obs_s[RESP_EQ] = cmp_eq;
    obs_s[RESP_LT] = cmp_lt;
  end

  assign mismatch_s   = (obs_s != exp_s);
  assign last_vec_s   = (a_q == OP_MAX) && (b_q == OP_MAX);
  assign settle_end_s = (settle_q == SETTLE_LAST);

  // State register.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= ST_IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  // Next-state logic; abort takes priority in every active state.
  always_comb begin
    state_d = state_q;
    case (state_q)
      ST_IDLE: begin
        if (abort)      state_d = ST_IDLE;
        else if (start) state_d = ST_FIRST;
        else            state_d = ST_IDLE;
      end
      ST_WAIT: begin
        if (abort)             state_d = ST_IDLE;
        else if (settle_end_s) state_d = ST_CHECK;
        else                   state_d = ST_WAIT;
      end
      ST_CHECK: begin
        if (abort)           state_d = ST_IDLE;
        else if (last_vec_s) state_d = ST_DONE;
        else                 state_d = ST_FIRST;
      end
      ST_DONE: state_d = ST_IDLE;
      default: state_d = ST_IDLE;
    endcase
  end

  // Datapath next values: operand walk, settle count, error bookkeeping.
  always_comb begin
    a_d      = a_q;
    b_d      = b_q;
    settle_d = settle_q;
    busy_d   = busy_q;
    done_d   = 1'b0;
    pass_d   = pass_q;
    err_d    = err_q;
    fa_d     = fa_q;
    fb_d     = fb_q;
    fo_d     = fo_q;
    case (state_q)
      ST_IDLE: begin
        a_d    = '0;
        b_d    = '0;
        busy_d = 1'b0;
        if (abort) begin
          pass_d = 1'b0;
        end else if (start) begin
          busy_d   = 1'b1;
          pass_d   = 1'b0;
          err_d    = '0;
          fa_d     = '0;
          fb_d     = '0;
          fo_d     = 3'b000;
          settle_d = '0;
        end else begin
          settle_d = '0;
        end
      end
      ST_WAIT: begin
        if (abort) begin
          busy_d = 1'b0;
          pass_d = 1'b0;
          a_d    = '0;
          b_d    = '0;
        end else if (settle_end_s) begin
          settle_d = '0;
        end else begin
          settle_d = settle_q + SETTLE_ONE;
        end
      end
      ST_CHECK: begin
        if (abort) begin
          busy_d = 1'b0;
          pass_d = 1'b0;
          a_d    = '0;
          b_d    = '0;
        end else begin
          settle_d = '0;
          if (mismatch_s) begin
            err_d = err_q + ERR_ONE;
            if (err_q == '0) begin
              fa_d = a_q;
              fb_d = b_q;
              fo_d = obs_s;
            end else begin
              fo_d = fo_q;
            end
          end else begin
            err_d = err_q;
          end
          // b is the inner loop; the final pair wraps both back to zero.
          b_d = b_q + OP_ONE;
          if (b_q == OP_MAX) a_d = a_q + OP_ONE;
          else               a_d = a_q;
          if (last_vec_s) begin
            done_d = 1'b1;
            busy_d = 1'b0;
            pass_d = (err_q == '0) && !mismatch_s;
          end else begin
            done_d = 1'b0;
          end
        end
      end
      ST_DONE: begin
        busy_d = 1'b0;
        if (abort) pass_d = 1'b0;
        else       pass_d = pass_q;
      end
      default: begin
        busy_d = 1'b0;
        a_d    = '0;
        b_d    = '0;
      end
    endcase
  end

  // Datapath and output registers.
  always_ff @(posedge clk) begin
    if (rst) begin
      a_q      <= '0;
      b_q      <= '0;
      settle_q <= '0;
      busy_q   <= 1'b0;
      done_q   <= 1'b0;
      pass_q   <= 1'b0;
      err_q    <= '0;
      fa_q     <= '0;
      fb_q     <= '0;
      fo_q     <= 3'b000;
    end else begin
      a_q      <= a_d;
      b_q      <= b_d;
      settle_q <= settle_d;
      busy_q   <= busy_d;
      done_q   <= done_d;
      pass_q   <= pass_d;
      err_q    <= err_d;
      fa_q     <= fa_d;
      fb_q     <= fb_d;
      fo_q     <= fo_d;
    end
  end

  assign busy      = busy_q;
  assign done      = done_q;
  assign pass      = pass_q;
  assign err_count = err_q;
  assign fail_a    = fa_q;
  assign fail_b    = fb_q;
  assign fail_obs  = fo_q;
  assign cmp_a     = a_q;
  assign cmp_b     = b_q;

endmodule

// File: doc/cmp_bist_ctrl.md
# cmp_bist_ctrl

Built-in self-test sequencer for the project's unsigned magnitude comparator (outputs A_gt_B, A_eq_B, A_lt_B). On a start request it drives every (A, B) operand pair onto the comparator and waits a programmable settle time. It then samples the three flags and checks them against a golden model, accumulating an error count and capturing the first failing vector. It sits between the top-level wrapper's control inputs and the comparator instance, and replaces open-loop sweeping with an on-chip pass/fail verdict.

## Interface
- WIDTH, 2: comparator operand width in bits.
- SETTLE, 1: cycles operands are held before the response is sampled (0 allowed).
- ERRW, 2*WIDTH+1: error counter width. It can hold the worst case of 2^(2*WIDTH) errors without saturating.

Ports:
- clk  in  1  sole clock; all state updates on its rising edge.
- rst  in  1  synchronous, active-high reset.
- start  in  1  begin a sweep; sampled only in IDLE.
- abort  in  1  synchronous cancel of a running sweep.
- busy  out  1  high while a sweep is in progress.
- done  out  1  one-cycle pulse when a sweep completes (not on abort).
- pass  out  1  level: last completed sweep had zero errors.
- err_count  out  ERRW  mismatching vectors in the last sweep.
- fail_a, fail_b  out  WIDTH each  operands of the first failing vector.
- fail_obs  out  3  observed {gt,eq,lt} at the first failure.
- cmp_a, cmp_b  out  WIDTH each  registered operands driven to the comparator.
- cmp_gt, cmp_eq, cmp_lt  in  1 each  comparator response.

## Operation
- FSM states: IDLE, WAIT, CHECK, DONE. Reset enters IDLE.
- On reset, every output is 0 (busy, done, pass, err_count, fail_*, cmp_a, cmp_b).
- **IDLE:**
  - cmp_a = cmp_b = 0.
  - abort=1 keeps the FSM in IDLE; abort wins over a simultaneous start.
  - start=1 clears err_count, fail_a, fail_b, fail_obs and pass, loads a=b=0, and sets busy.
  - The next state is WAIT when SETTLE>0, otherwise CHECK.
- **WAIT:** a settle counter runs for exactly SETTLE cycles, then the FSM moves to CHECK. Operands are stable throughout.
- **CHECK:** one cycle.
  - Expected response is gt=(a>b), eq=(a==b), lt=(a<b), all unsigned.
  - A vector fails when the observed triple differs from the expected triple. This includes non-one-hot responses such as 000 or 011.
  - On failure, err_count increments. If err_count was 0 beforehand, {a, b, observed} is captured into fail_a, fail_b, fail_obs.
  - Operand advance: b is the inner loop and a the outer, both counting upward. b wraps from 2^WIDTH-1 to 0 and a increments on that wrap.
  - After the vector a=b=2^WIDTH-1, the FSM goes to DONE. Otherwise it returns to WAIT (or CHECK when SETTLE=0) with the new operands.
- **DONE:** one cycle.
  - done=1 and busy=0.
  - pass is set to 1 when err_count==0; it then holds until the next accepted start, abort or reset.
  - The FSM returns to IDLE unconditionally; a start in DONE is ignored.
- **Abort** in WAIT or CHECK: the FSM goes to IDLE next cycle with busy=0, cmp_a=cmp_b=0 and pass=0. err_count and fail_* keep their partial values; done is not pulsed.
- start asserted while busy is ignored. start has no level/edge requirement; holding it high restarts each time the FSM reaches IDLE.
- Reset mid-sweep has the same effect as power-up reset: all state and outputs are cleared.

## Timing
- Each vector takes SETTLE+1 cycles; a full sweep is 2^(2*WIDTH)*(SETTLE+1) cycles.
- With start accepted at edge k:
  - busy is high from edge k.
  - The final CHECK is evaluated at edge k+N, with N = 2^(2*WIDTH)*(SETTLE+1), and done is high in the cycle after edge k+N.
  - For the defaults, N=32.
- cmp_a and cmp_b change only on the edge that leaves CHECK (or the start-accept edge). The comparator therefore sees each operand pair for exactly SETTLE+1 cycles.
- With start held high, the done pulse repeats every N+2 cycles (DONE 1 cycle, IDLE 1 cycle).
- err_count, fail_* and pass are registered and valid from the cycle done is high.

## Structure
- Shared package cmp_bist_pkg holds:
  - the state encoding (IDLE=0, WAIT=1, CHECK=2, DONE=3);
  - the response bit-order constant {gt,eq,lt};
  - the default WIDTH.
- One sub-module, cmp_ref_model: a purely combinational golden comparator producing the expected triple from a and b. The bench reuses it as its scoreboard.
- Counters (a, b, settle, err) and the FSM live in cmp_bist_ctrl.

## Test plan
- Correct comparator, defaults, one start pulse: busy for 32 cycles; done pulses once 32 cycles after acceptance; pass=1, err_count=0; cmp_a/cmp_b walk 00/00, 00/01 … 11/11 in order.
- Comparator with gt stuck at 0: err_count=6, pass=0, fail_a=01, fail_b=00, fail_obs=000.
- Comparator asserting eq and lt together when a==b: err_count=4, fail_a=00, fail_b=00, fail_obs=011.
- Abort raised during the WAIT of vector a=01, b=01: busy=0 next cycle, no done, pass=0, cmp_a=cmp_b=0. A following start completes a clean sweep with pass=1.
- start and abort asserted together in IDLE: no sweep starts, busy stays 0. Separately, start held high for 100 cycles with SETTLE=0: done pulses every 18 cycles.
- rst asserted during sweep vector 9, then released: every output is 0 on the following cycle and the FSM is in IDLE. With SETTLE=3, a sweep takes 64 cycles.
